// File: rtl/br_pkg.sv
// Shared types for the branch-resolution stage:
// op encoding, default widths and the registered result bundle.
package br_pkg;

    localparam int BR_OP_W  = 4;
    localparam int BR_XLEN  = 64;
    localparam int BR_TAG_W = 5;

    typedef enum logic [BR_OP_W-1:0] {
        OP_NONE = 4'd0,
        OP_JAL  = 4'd1,
        OP_JALR = 4'd2,
        OP_BEQ  = 4'd3,
        OP_BNE  = 4'd4,
        OP_BLT  = 4'd5,
        OP_BGE  = 4'd6,
        OP_BLTU = 4'd7,
        OP_BGEU = 4'd8
    } br_op_e;

    typedef struct packed {
        logic [BR_TAG_W-1:0] tag;
        logic                taken;
        logic [BR_XLEN-1:0]  target;
        logic [BR_XLEN-1:0]  link;
        logic                redirect;
        logic [BR_XLEN-1:0]  redirect_pc;
        logic                misalign;
    } br_result_t;

endpackage

// File: rtl/br_cond.sv
// Branch condition evaluator: purely combinational (op, rs1, rs2) -> taken.
// Jumps are always taken; NONE and unknown codes are never taken.
module br_cond
    import br_pkg::*;
#(
    parameter int XLEN = BR_XLEN
) (
    input  br_op_e          op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_i == rs2_i);
    assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_u = (rs1_i < rs2_i);

    always_comb begin
        taken_o = 1'b0;
        unique case (op_i)
            OP_JAL,
            OP_JALR: taken_o = 1'b1;
            OP_BEQ:  taken_o = eq;
            OP_BNE:  taken_o = !eq;
            OP_BLT:  taken_o = lt_s;
            OP_BGE:  taken_o = !lt_s;
            OP_BLTU: taken_o = lt_u;
            OP_BGEU: taken_o = !lt_u;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_resolve.sv
// Branch-resolution stage: 1-entry registered result, redirect, counters.
// Define BR_MISALIGN_EN to flag taken targets with bit 1 set as misaligned.
module br_resolve
    import br_pkg::*;
#(
    parameter int XLEN  = BR_XLEN,
    parameter int TAG_W = BR_TAG_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic             out_redirect,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_misalign,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    br_op_e          op;
    logic            taken;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] pc_sum;
    logic [XLEN-1:0] rs1_sum;
    logic [XLEN-1:0] target;
    logic            misalign;
    logic            mispred;
    logic            accept;

    br_result_t      res_d, res_q;
    logic            valid_q;
    logic [CNT_W-1:0] br_cnt_d, br_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_d, mispred_cnt_q;

    assign op = br_op_e'(in_op);

    br_cond #(.XLEN(XLEN)) u_cond (
        .op_i    (op),
        .rs1_i   (in_rs1),
        .rs2_i   (in_rs2),
        .taken_o (taken)
    );

    assign link    = in_pc + XLEN'(4);
    assign pc_sum  = in_pc + in_imm;
    assign rs1_sum = in_rs1 + in_imm;

    always_comb begin
        target = pc_sum;
        unique case (op)
            OP_NONE: target = link;
            OP_JALR: target = {rs1_sum[XLEN-1:1], 1'b0};
            default: target = pc_sum;
        endcase
    end

`ifdef BR_MISALIGN_EN
    assign misalign = taken & target[1];
`else
    assign misalign = 1'b0;
`endif

    // A misaligned target traps instead of redirecting.
    assign mispred = ((taken != in_pred_taken) |
                      (taken & (target != in_pred_target))) & !misalign;

    always_comb begin
        res_d             = '0;
        res_d.tag         = in_tag;
        res_d.taken       = taken;
        res_d.target      = target;
        res_d.link        = link;
        res_d.redirect    = mispred;
        res_d.redirect_pc = taken ? target : link;
        res_d.misalign    = misalign;
    end

    assign in_ready = !valid_q | out_ready;
    assign accept   = in_valid & in_ready & !flush;

    always_comb begin
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (accept) begin
            if (op != OP_NONE && br_cnt_q != '1)
                br_cnt_d = br_cnt_q + CNT_W'(1);
            if (mispred && mispred_cnt_q != '1)
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            res_q         <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (flush)
                valid_q <= 1'b0;
            else if (accept)
                valid_q <= 1'b1;
            else if (out_ready)
                valid_q <= 1'b0;
            if (accept)
                res_q <= res_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_tag         = res_q.tag;
    assign out_taken       = res_q.taken;
    assign out_target      = res_q.target;
    assign out_link        = res_q.link;
    assign out_redirect    = res_q.redirect;
    assign out_redirect_pc = res_q.redirect_pc;
    assign out_misalign    = res_q.misalign;
    assign br_cnt          = br_cnt_q;
    assign mispred_cnt     = mispred_cnt_q;

endmodule

// File: tb/tb_br_resolve.sv
// Scoreboard bench for br_resolve: driver pushes reference results,
// a negedge monitor pops and compares whatever the stage presents.
module tb_br_resolve;

    localparam logic [31:0] CMAX = 32'hFFFF_FFFF;

    typedef struct {
        logic [4:0]  tag;
        logic        taken;
        logic [63:0] target;
        logic [63:0] link;
        logic        redirect;
        logic [63:0] rpc;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [63:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
    logic        in_pred_taken = 1'b0;
    logic [63:0] in_pred_target = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_tag;
    logic        out_taken;
    logic [63:0] out_target, out_link, out_redirect_pc;
    logic        out_redirect, out_misalign;
    logic [31:0] br_cnt, mispred_cnt;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    exp_t        cur;
    logic        have = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_br = '0, m_mp = '0;
    logic [4:0]  tag_ctr = '0;

    br_resolve dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_taken(out_taken), .out_target(out_target),
        .out_link(out_link), .out_redirect(out_redirect),
        .out_redirect_pc(out_redirect_pc), .out_misalign(out_misalign),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op,
            input logic [63:0] pc, rs1, rs2, imm,
            input logic pt, input logic [63:0] ptgt);
        exp_t e;
        e.tag  = '0;
        e.link = pc + 64'd4;
        e.target = pc + imm;
        e.taken  = 1'b0;
        case (op)
            4'd0: e.target = pc + 64'd4;
            4'd1: e.taken = 1'b1;
            4'd2: begin
                e.taken  = 1'b1;
                e.target = (rs1 + imm) & ~64'd1;
            end
            4'd3: e.taken = (rs1 == rs2);
            4'd4: e.taken = (rs1 != rs2);
            4'd5: e.taken = ($signed(rs1) < $signed(rs2));
            4'd6: e.taken = ($signed(rs1) >= $signed(rs2));
            4'd7: e.taken = (rs1 < rs2);
            4'd8: e.taken = (rs1 >= rs2);
            default: e.taken = 1'b0;
        endcase
`ifdef BR_MISALIGN_EN
        e.mis = e.taken && e.target[1];
`else
        e.mis = 1'b0;
`endif
        e.redirect = ((e.taken != pt) || (e.taken && e.target != ptgt))
                     && !e.mis;
        e.rpc = e.taken ? e.target : e.link;
        return e;
    endfunction

    // One clock of stimulus; returns at posedge+1 with the model updated.
    task automatic step(input logic v, input logic [3:0] op,
            input logic [63:0] pc, rs1, rs2, imm,
            input logic pt, input logic [63:0] ptgt,
            input logic rdy, input logic fl);
        logic acc;
        exp_t e;
        in_valid = v; in_op = op; in_pc = pc; in_rs1 = rs1;
        in_rs2 = rs2; in_imm = imm; in_pred_taken = pt;
        in_pred_target = ptgt; in_tag = tag_ctr;
        out_ready = rdy; flush = fl;
        @(negedge clk);
        acc = v && in_ready && !fl;
        e = model(op, pc, rs1, rs2, imm, pt, ptgt);
        e.tag = tag_ctr;
        @(posedge clk);
        #1;
        if (acc) begin
            sb.push_back(e);
            if (op != 4'd0 && m_br != CMAX) m_br = m_br + 1;
            if (e.redirect && m_mp != CMAX) m_mp = m_mp + 1;
            tag_ctr = tag_ctr + 5'd1;
        end
        if (fl) m_valid = 1'b0;
        else if (acc) m_valid = 1'b1;
        else if (rdy) m_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
            chk("in_ready", {63'd0, in_ready},
                {63'd0, (!out_valid || out_ready)});
            chk("br_cnt", {32'd0, br_cnt}, {32'd0, m_br});
            chk("mispred_cnt", {32'd0, mispred_cnt}, {32'd0, m_mp});
            if (out_valid) begin
                if (!have) begin
                    if (sb.size() == 0) begin
                        chk("sb_empty", 64'd1, 64'd0);
                    end else begin
                        cur = sb.pop_front();
                    end
                    have = 1'b1;
                end
                chk("tag", {59'd0, out_tag}, {59'd0, cur.tag});
                chk("taken", {63'd0, out_taken}, {63'd0, cur.taken});
                chk("target", out_target, cur.target);
                chk("link", out_link, cur.link);
                chk("redirect", {63'd0, out_redirect}, {63'd0, cur.redirect});
                chk("redirect_pc", out_redirect_pc, cur.rpc);
                chk("misalign", {63'd0, out_misalign}, {63'd0, cur.mis});
                if (out_ready || flush) have = 1'b0;
            end else begin
                have = 1'b0;
            end
        end
    end

    initial begin
        logic [63:0] a, b, pc, imm, t;
        logic [3:0]  op;
        logic [31:0] sv_br, sv_mp;
        exp_t        e;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_target", out_target, 64'd0);
        chk("rst_br_cnt", {32'd0, br_cnt}, 64'd0);
        chk("rst_mp_cnt", {32'd0, mispred_cnt}, 64'd0);
        rst_n = 1'b1;

        // BEQ equal operands, predicted not taken
        step(1, 4'd3, 64'h1000, 64'd5, 64'd5, 64'h20, 0, 64'h0, 1, 0);
        chk("t1_taken", {63'd0, out_taken}, 64'd1);
        chk("t1_target", out_target, 64'h1020);
        chk("t1_redirect", {63'd0, out_redirect}, 64'd1);
        chk("t1_rpc", out_redirect_pc, 64'h1020);
        chk("t1_mp_cnt", {32'd0, mispred_cnt}, 64'd1);

        // BLT taken, BLTU not taken, both predicted correctly
        step(1, 4'd5, 64'h2000, '1, 64'd1, 64'h40, 1, 64'h2040, 1, 0);
        chk("t2_blt_taken", {63'd0, out_taken}, 64'd1);
        chk("t2_blt_redir", {63'd0, out_redirect}, 64'd0);
        step(1, 4'd7, 64'h2004, '1, 64'd1, 64'h40, 0, 64'h0, 1, 0);
        chk("t2_bltu_taken", {63'd0, out_taken}, 64'd0);
        chk("t2_bltu_redir", {63'd0, out_redirect}, 64'd0);
        chk("t2_br_cnt", {32'd0, br_cnt}, 64'd3);

        // JALR clears bit 0
        step(1, 4'd2, 64'h3000, 64'h2001, 64'd0, 64'h4, 1, 64'h2004, 1, 0);
        chk("t3_target", out_target, 64'h2004);
        chk("t3_link", out_link, 64'h3004);
        chk("t3_redir", {63'd0, out_redirect}, 64'd0);
`ifdef BR_MISALIGN_EN
        step(1, 4'd2, 64'h3000, 64'h2002, 64'd0, 64'h4, 1, 64'h2006, 1, 0);
        chk("t3_misalign", {63'd0, out_misalign}, 64'd1);
        chk("t3_mis_redir", {63'd0, out_redirect}, 64'd0);
`endif
        // JAL with PC wrap-around; NONE predicted taken
        step(1, 4'd1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 64'h20, 1, 64'h10, 1, 0);
        chk("wrap_target", out_target, 64'h10);
        step(1, 4'd0, 64'h4000, 0, 0, 64'h8, 1, 64'h4008, 1, 0);
        chk("none_rpc", out_redirect_pc, 64'h4004);

        // back-pressure, then drain+accept in one cycle
        step(1, 4'd4, 64'h5000, 1, 2, 64'h10, 1, 64'h5010, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 4'd6, 64'h6000, 3, 3, 64'h8, 0, 0, 0, 0);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        step(1, 4'd6, 64'h6000, 3, 3, 64'h8, 0, 0, 1, 0);
        chk("drain_acc_valid", {63'd0, out_valid}, 64'd1);
        chk("drain_acc_target", out_target, 64'h6008);

        // flush with a held result and a new op offered
        sv_br = br_cnt;
        sv_mp = mispred_cnt;
        step(1, 4'd1, 64'h7000, 0, 0, 64'h8, 0, 0, 0, 0);
        step(1, 4'd1, 64'h7000, 0, 0, 64'h8, 0, 0, 1, 1);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_br_cnt", {32'd0, br_cnt}, {32'd0, sv_br});
        chk("flush_mp_cnt", {32'd0, mispred_cnt}, {32'd0, sv_mp});

        // saturating branch counter from a preloaded state
        force dut.br_cnt_q = CMAX;
        m_br = CMAX;
        step(0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0);
        release dut.br_cnt_q;
        step(1, 4'd4, 64'h8000, 1, 2, 64'h8, 1, 64'h8008, 1, 0);
        chk("sat_br_cnt", {32'd0, br_cnt}, {32'd0, CMAX});

        // async reset while a result is held
        step(1, 4'd3, 64'h9000, 7, 7, 64'h8, 1, 64'h9008, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_target", out_target, 64'd0);
        chk("arst_taken", {63'd0, out_taken}, 64'd0);
        chk("arst_br_cnt", {32'd0, br_cnt}, 64'd0);
        chk("arst_mp_cnt", {32'd0, mispred_cnt}, 64'd0);
        sb.delete();
        m_valid = 1'b0;
        m_br = '0;
        m_mp = '0;
        #1 rst_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            op = 4'($urandom_range(0, 8));
            a  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = a;
                1: begin
                    a = 64'($signed($urandom_range(0, 6)) - 3);
                    b = 64'($signed($urandom_range(0, 6)) - 3);
                end
                default: b = {$urandom, $urandom};
            endcase
            pc  = {$urandom, $urandom} & ~64'd3;
            t   = 64'($urandom_range(0, 4095));
            imm = {{52{t[11]}}, t[11:0]};
            e = model(op, pc, a, b, imm, 0, 0);
            if ($urandom_range(0, 1) == 0)
                step($urandom_range(0, 3) != 0, op, pc, a, b, imm,
                     e.taken, e.target,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            else
                step($urandom_range(0, 3) != 0, op, pc, a, b, imm,
                     1'($urandom), {$urandom, $urandom} & ~64'd1,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        step(0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
